// File: rtl/min_pkg.sv
// Shared constants and the constant-width helper used by the min-search tree.
package min_pkg;

    localparam int DEFAULT_ELEMENT_BIT_DEPTH = 14;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/min_cmp2.sv
// Two-input (value, index) minimum select; on equal values the a side (lower lane) is kept.
module min_cmp2 #(
    parameter int VAL_W = 14,
    parameter int IDX_W = 4
) (
    input  logic [VAL_W-1:0] a_val,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [VAL_W-1:0] b_val,
    input  logic [IDX_W-1:0] b_idx,
    output logic [VAL_W-1:0] y_val,
    output logic [IDX_W-1:0] y_idx
);

    logic take_b;

    assign take_b = (b_val < a_val);
    assign y_val  = take_b ? b_val : a_val;
    assign y_idx  = take_b ? b_idx : a_idx;

endmodule

// File: rtl/min_tree_acc.sv
// Streaming minimum search: a registered binary compare tree per beat, followed by
// a running accumulator that reports the group minimum and its flat index.
module min_tree_acc
    import min_pkg::*;
#(
    parameter int ELEMENT_BIT_DEPTH = DEFAULT_ELEMENT_BIT_DEPTH,
    parameter int NUM_ELEMENTS      = 16,
    parameter int MAX_BEATS         = 64,
    localparam int LANE_W = clog2(NUM_ELEMENTS),
    localparam int IDX_W  = (clog2(MAX_BEATS * NUM_ELEMENTS) < 1) ? 1
                                                                   : clog2(MAX_BEATS * NUM_ELEMENTS)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    input  logic [ELEMENT_BIT_DEPTH*NUM_ELEMENTS-1:0]   in_array,
    output logic                                        out_valid,
    output logic [ELEMENT_BIT_DEPTH-1:0]                out_min,
    output logic [IDX_W-1:0]                            out_index,
    output logic                                        out_overflow
);

    // Handshake: a beat is taken on every rising edge with in_valid=1 (no backpressure);
    // out_valid is a single-cycle pulse and the out_* fields hold until the next pulse.

    localparam int W     = ELEMENT_BIT_DEPTH;
    localparam int NODES = NUM_ELEMENTS - 1;
    localparam int CNT_W = (clog2(MAX_BEATS) < 1) ? 1 : clog2(MAX_BEATS);

    // Heap-ordered tree: node k has children 2k+1 (lower lanes) and 2k+2; heap slots
    // at or above NODES are the input lanes themselves.
    logic [W-1:0]      node_val  [NODES];
    logic [LANE_W-1:0] node_lane [NODES];
    logic [W-1:0]      sel_val   [NODES];
    logic [LANE_W-1:0] sel_lane  [NODES];

    for (genvar k = 0; k < NODES; k++) begin : g_node
        logic [W-1:0]      a_val;
        logic [W-1:0]      b_val;
        logic [LANE_W-1:0] a_lane;
        logic [LANE_W-1:0] b_lane;

        if (2 * k + 1 >= NODES) begin : g_leaf
            assign a_val  = in_array[(2*k+1-NODES)*W +: W];
            assign b_val  = in_array[(2*k+2-NODES)*W +: W];
            assign a_lane = LANE_W'(2 * k + 1 - NODES);
            assign b_lane = LANE_W'(2 * k + 2 - NODES);
        end else begin : g_inner
            assign a_val  = node_val[2*k+1];
            assign b_val  = node_val[2*k+2];
            assign a_lane = node_lane[2*k+1];
            assign b_lane = node_lane[2*k+2];
        end

        min_cmp2 #(
            .VAL_W (W),
            .IDX_W (LANE_W)
        ) u_cmp (
            .a_val (a_val),
            .a_idx (a_lane),
            .b_val (b_val),
            .b_idx (b_lane),
            .y_val (sel_val[k]),
            .y_idx (sel_lane[k])
        );
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NODES; k++) begin
            node_val[k]  <= sel_val[k];
            node_lane[k] <= sel_lane[k];
        end
    end

    // Bit LANE_W-1 of these shift registers lines up with the root node.
    logic [LANE_W-1:0] stage_valid;
    logic [LANE_W-1:0] stage_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            stage_last  <= '0;
        end else begin
            for (int j = LANE_W - 1; j > 0; j--) begin
                stage_valid[j] <= stage_valid[j-1];
                stage_last[j]  <= stage_last[j-1];
            end
            stage_valid[0] <= in_valid;
            stage_last[0]  <= in_valid & in_last;
        end
    end

    logic             tree_valid;
    logic             tree_last;
    logic             first;
    logic             cnt_full;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] this_cnt;
    logic             last_slot;
    logic [W-1:0]     run_min;
    logic [IDX_W-1:0] run_idx;
    logic             run_ovf;
    logic             take;
    logic [IDX_W-1:0] beat_idx;
    logic [W-1:0]     new_min;
    logic [IDX_W-1:0] new_idx;
    logic             new_ovf;

    assign tree_valid = stage_valid[LANE_W-1];
    assign tree_last  = stage_last[LANE_W-1];
    assign this_cnt   = first ? '0 : beat_cnt;
    assign last_slot  = (this_cnt == CNT_W'(MAX_BEATS - 1));
    assign beat_idx   = IDX_W'({this_cnt, node_lane[0]});
    assign take       = first | (node_val[0] < run_min);
    assign new_min    = take ? node_val[0] : run_min;
    assign new_idx    = take ? beat_idx : run_idx;
    // A beat arriving after the last slot was used marks the whole group as overflowed.
    assign new_ovf    = ~first & (run_ovf | cnt_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            first        <= 1'b1;
            beat_cnt     <= '0;
            cnt_full     <= 1'b0;
            run_min      <= '1;
            run_idx      <= '0;
            run_ovf      <= 1'b0;
            out_valid    <= 1'b0;
            out_min      <= '1;
            out_index    <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (tree_valid) begin
                run_min  <= new_min;
                run_idx  <= new_idx;
                run_ovf  <= new_ovf;
                first    <= tree_last;
                beat_cnt <= last_slot ? this_cnt : this_cnt + 1'b1;
                cnt_full <= last_slot;
                if (tree_last) begin
                    out_valid    <= 1'b1;
                    out_min      <= new_min;
                    out_index    <= new_idx;
                    out_overflow <= new_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_min_tree_acc.sv
// Directed-vector bench for min_tree_acc with a queue scoreboard and a negedge monitor.
module tb_min_tree_acc;

    localparam int W    = 14;
    localparam int N    = 16;
    localparam int MAXB = 64;
    localparam int IDXW = 10;
    localparam int LAT  = 5;
    localparam int EW   = 1 + IDXW + W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_last;
    logic [W*N-1:0]    in_array;
    logic              out_valid;
    logic [W-1:0]      out_min;
    logic [IDXW-1:0]   out_index;
    logic              out_overflow;

    min_tree_acc dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_array     (in_array),
        .out_valid    (out_valid),
        .out_min      (out_min),
        .out_index    (out_index),
        .out_overflow (out_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            passed = 0;
    int            total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: got out_valid=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                logic [EW-1:0] e;
                int            ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("out_min",      32'(out_min),      32'(e[W-1:0]));
                check("out_index",    32'(out_index),    32'(e[W+IDXW-1:W]));
                check("out_overflow", 32'(out_overflow), 32'(e[EW-1]));
                check("latency",      32'(cyc),          32'(ec));
            end
        end
    end

    // drivers
    function automatic logic [W*N-1:0] fill(input logic [W-1:0] v);
        logic [W*N-1:0] a;
        for (int i = 0; i < N; i++) a[i*W +: W] = v;
        return a;
    endfunction

    task automatic drive_beat(input logic [W*N-1:0] arr, input logic last,
                              input logic [W-1:0] e_min, input logic [IDXW-1:0] e_idx,
                              input logic e_ovf);
        in_valid = 1'b1;
        in_last  = last;
        in_array = arr;
        if (last) begin
            exp_q.push_back({e_ovf, e_idx, e_min});
            exp_cyc_q.push_back(cyc + LAT);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_array = fill(14'h2aaa);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    logic [W-1:0]   lanes33 [N] = '{14'h1875, 14'h17b9, 14'h1d59, 14'h1ea6, 14'h196b, 14'h17c9,
                                    14'h1ef9, 14'h1c98, 14'h1fb3, 14'h16b7, 14'h1bd8, 14'h1286,
                                    14'h1f4d, 14'h1c68, 14'h1d82, 14'h1769};
    logic [W*N-1:0] arr;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_array = '0;
        idle(3);
        check("rst_out_valid",    32'(out_valid),    32'd0);
        check("rst_out_min",      32'(out_min),      32'h3fff);
        check("rst_out_index",    32'(out_index),    32'd0);
        check("rst_out_overflow", 32'(out_overflow), 32'd0);
        rst = 1'b0;
        idle(2);

        // single beat, min 0x1286 at lane 11
        for (int i = 0; i < N; i++) arr[i*W +: W] = lanes33[i];
        drive_beat(arr, 1'b1, 14'h1286, 10'd11, 1'b0);

        // all-equal ties over two beats: lowest index wins
        drive_beat(fill(14'h0100), 1'b0, '0, '0, 1'b0);
        drive_beat(fill(14'h0100), 1'b1, 14'h0100, 10'd0, 1'b0);

        // three beats, minimum at beat 2 lane 7, then a single-beat group right behind
        drive_beat(fill(14'h0006), 1'b0, '0, '0, 1'b0);
        drive_beat(fill(14'h0006), 1'b0, '0, '0, 1'b0);
        arr = fill(14'h0006);
        arr[7*W +: W] = 14'h0005;
        drive_beat(arr, 1'b1, 14'h0005, 10'd39, 1'b0);
        arr = fill(14'h0100);
        arr[3*W +: W] = 14'h0000;
        drive_beat(arr, 1'b1, 14'h0000, 10'd3, 1'b0);

        // two-beat group with 3 idle cycles between beats: index 1*16+9
        arr = fill(14'h0200);
        arr[5*W +: W] = 14'h0050;
        drive_beat(arr, 1'b0, '0, '0, 1'b0);
        idle(3);
        arr = fill(14'h0200);
        arr[9*W +: W] = 14'h0040;
        drive_beat(arr, 1'b1, 14'h0040, 10'd25, 1'b0);

        // overflow: MAXB+2 beats, index clamps to beat slot MAXB-1
        for (int b = 0; b < MAXB + 2; b++) begin
            arr = fill(14'h3fff);
            if (b == MAXB + 1) begin
                arr[1*W +: W] = 14'h0001;
                drive_beat(arr, 1'b1, 14'h0001, 10'((MAXB - 1) * 16 + 1), 1'b1);
            end else begin
                drive_beat(arr, 1'b0, '0, '0, 1'b0);
            end
        end
        drain("drain_before_rst");

        // reset mid-group: partial group (with a smaller value) must vanish
        arr = fill(14'h0200);
        arr[2*W +: W] = 14'h0001;
        drive_beat(arr, 1'b0, '0, '0, 1'b0);
        drive_beat(arr, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        idle(1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_min",   32'(out_min),   32'h3fff);
        rst = 1'b0;
        arr = fill(14'h0200);
        arr[4*W +: W] = 14'h0010;
        drive_beat(arr, 1'b1, 14'h0010, 10'd4, 1'b0);

        drain("drain_final");
        idle(10);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/min_tree_acc.md
MIN_TREE_ACC -- requirements
Module: min_tree_acc

Interface
REQ-001 SHALL have parameter ELEMENT_BIT_DEPTH, default 14, giving the unsigned width of each element (SAD value).
REQ-002 SHALL have parameter NUM_ELEMENTS, default 16, giving the lanes per beat; it must be a power of two and at least 2.
REQ-003 SHALL have parameter MAX_BEATS, default 64, giving the maximum number of beats per group; it must be at least 1.
REQ-004 SHALL define derived widths: LANE_W = clog2(NUM_ELEMENTS); IDX_W = clog2(MAX_BEATS*NUM_ELEMENTS), minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_array and in_last are valid this cycle.
REQ-008 SHALL have port in_last, input, 1 bit: this beat closes the current group.
REQ-009 SHALL have port in_array, input, ELEMENT_BIT_DEPTH*NUM_ELEMENTS bits: lane i occupies bits [(i+1)*ELEMENT_BIT_DEPTH-1 : i*ELEMENT_BIT_DEPTH].
REQ-010 SHALL have port out_valid, output, 1 bit: a one-cycle pulse presenting a group result.
REQ-011 SHALL have port out_min, output, ELEMENT_BIT_DEPTH bits: the group minimum.
REQ-012 SHALL have port out_index, output, IDX_W bits: beat_number*NUM_ELEMENTS + lane of the minimum.
REQ-013 SHALL have port out_overflow, output, 1 bit: the group exceeded MAX_BEATS.

Function
REQ-014 SHALL accept one beat per cycle whenever in_valid=1; there is no backpressure, and in_array/in_last are ignored when in_valid=0.
REQ-015 SHALL reduce each beat through a LANE_W-level binary compare tree, with every level registered and carrying (value, lane, valid, last) forward.
REQ-016 SHALL resolve ties at every tree node by keeping the lower lane, i.e. the right operand wins only when strictly smaller.
REQ-017 SHALL feed the tree output into one accumulator stage that holds running min, running index and beat counter.
REQ-018 SHALL load (not compare) the first beat of a group: the first beat after reset, or the first beat after a last beat.
REQ-019 SHALL replace the running min on later beats only when the beat min is strictly smaller, so that the earlier (lower) index wins ties.
REQ-020 SHALL form the index of a beat's candidate as beat_cnt*NUM_ELEMENTS + lane, where beat_cnt starts at 0 per group.
REQ-021 SHALL pulse out_valid for exactly one cycle, LANE_W+1 cycles after the in_valid&in_last cycle, with no cycles added.
REQ-022 SHALL hold out_min, out_index and out_overflow stable from the out_valid pulse until the next pulse.
REQ-023 SHALL reset the accumulator so that a group's first beat may enter it in the cycle directly after the previous group's last beat.
REQ-024 SHALL support back-to-back groups, including single-beat groups, at full rate.
REQ-025 SHALL saturate beat_cnt at MAX_BEATS-1 when a group exceeds MAX_BEATS beats, keep comparing (indices clamp to the last beat slot), and assert out_overflow with that group's out_valid.
REQ-026 SHALL let in_valid gaps inside a group stall nothing and count no beats.
REQ-027 SHALL treat all values as unsigned, so the all-ones value is a legal candidate.

Reset
REQ-028 SHALL, while rst=1, clear all tree valid bits, the accumulator first-beat flag (set), and beat_cnt to 0.
REQ-029 SHALL, while rst=1, set out_valid=0, out_min=all-ones, out_index=0 and out_overflow=0.
REQ-030 SHALL, on rst mid-group, discard the partial group with no out_valid for it; the first valid beat after rst deasserts starts a new group.

Structure
REQ-031 SHALL place the clog2 function and the ELEMENT_BIT_DEPTH default constant in the shared package min_pkg.
REQ-032 SHALL use the sub-module min_cmp2 (combinational two-input (value, index) select, lower-index-on-tie), instantiated NUM_ELEMENTS-1 times by generate.

Verification
REQ-033 SHALL test a single beat with lanes 0..15 = 0x1875,0x17b9,0x1d59,0x1ea6,0x196b,0x17c9,0x1ef9,0x1c98,0x1fb3,0x16b7,0x1bd8,0x1286,0x1f4d,0x1c68,0x1d82,0x1769 and in_last=1 -> out_valid 5 cycles later, out_min=0x1286, out_index=11, out_overflow=0.
REQ-034 SHALL test ties with all lanes 0x0100 in beat 0 and beat 1 (last) -> out_min=0x0100, out_index=0.
REQ-035 SHALL test 3 beats with the minimum 0x0005 in beat 2 lane 7 and 0x0006 elsewhere -> out_index=39; then a single-beat group on the next cycle with lane 3=0 -> second pulse exactly 1 cycle after the first, out_index=3.
REQ-036 SHALL test an overflow group of MAX_BEATS+2 beats, all 0x3FFF except the last beat lane 1=0x0001 -> out_overflow=1, out_min=0x0001, out_index=(MAX_BEATS-1)*16+1.
REQ-037 SHALL test rst=1 for one cycle after 2 beats of a group, followed by a fresh 1-beat group with minimum 0x0010 in lane 4 -> exactly one out_valid, out_min=0x0010, out_index=4.
REQ-038 SHALL test in_valid gaps of 3 idle cycles between the beats of a 2-beat group -> the index counts only valid beats, and the latency is measured from the last beat.
